// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
//
// Round-robin packet arbiter: shares one downstream valid/ready channel
// between N_REQ upstream requesters. A grant is held from the first beat
// until the granted requester's last beat is accepted, so packets never
// interleave. The downstream side is a single register stage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester beat valid
//   req_data   per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   req_last   per-requester end-of-packet flag
//   req_ready  per-requester beat accept (only the granted bit can be high)
//   out_valid  registered output beat valid
//   out_data   registered output payload
//   out_last   registered output end-of-packet
//   out_src    registered index of the requester that produced out_data
//   out_ready  downstream accept
//   busy       high while a grant is held
// -----------------------------------------------------------------------------
module stream_rr_arbiter #(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 32,
  localparam int SRC_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [SRC_W-1:0]        out_src,
  input  logic                    out_ready,
  output logic                    busy
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Pointer starts at the highest index so requester 0 wins first.
  localparam logic [SRC_W-1:0] PTR_RST = SRC_W'(N_REQ - 1);

  // First valid requester searching last_idx+1, last_idx+2, ... modulo N_REQ.
  function automatic logic [SRC_W-1:0] rr_pick(
    input logic [N_REQ-1:0] valid,
    input logic [SRC_W-1:0] last_idx
  );
    logic [SRC_W-1:0] pick;
    logic [SRC_W-1:0] idx;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = SRC_W'((int'(last_idx) + k) % N_REQ);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    grant_q, grant_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [SRC_W-1:0]    out_src_q, out_src_d;

  logic [DATA_W-1:0]   lane_s [N_REQ];
  logic [SRC_W-1:0]    pick_idx_s;
  logic                grant_ready_s;
  logic                xfer_s;
  logic [DATA_W-1:0]   grant_data_s;
  logic                grant_last_s;
  logic [N_REQ-1:0]    req_ready_s;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane_s[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign pick_idx_s    = rr_pick(req_valid, ptr_q);
  // The granted requester may push whenever the output slot is empty or
  // being drained this cycle; out_ready reaches req_ready combinationally.
  assign grant_ready_s = (state_q == ST_LOCKED) && (!out_valid_q || out_ready);
  assign xfer_s        = grant_ready_s && req_valid[grant_q];
  assign grant_data_s  = lane_s[grant_q];
  assign grant_last_s  = req_last[grant_q];

  // One-hot ready toward the granted requester only.
  always_comb begin
    req_ready_s = '0;
    if (grant_ready_s) begin
      req_ready_s[grant_q] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Next-state logic for the grant FSM and the output register stage.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    case (state_q)
      ST_IDLE: begin
        // Arbitration cycle: no beat moves while the grant is being chosen.
        if (|req_valid) begin
          state_d = ST_LOCKED;
          grant_d = pick_idx_s;
          ptr_d   = pick_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (xfer_s && grant_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data_s;
      out_last_d  = grant_last_s;
      out_src_d   = grant_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State, grant/pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= PTR_RST;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign req_ready = req_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
//
// Directed bench for stream_rr_arbiter (N_REQ = 4, DATA_W = 32). A vector
// table covers reset, a single-requester packet and downstream backpressure;
// hand-written sequences cover fairness, a mid-packet upstream stall and a
// reset in the middle of a packet.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   lane_d [N];
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_src;
  logic           out_ready;
  logic           busy;

  int n_checks;
  int n_fail;

  assign req_data = {lane_d[3], lane_d[2], lane_d[1], lane_d[0]};

  stream_rr_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_n;
    logic [3:0] vld;
    logic [3:0] lst;
    logic [7:0] dat;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_busy;
    logic       e_ov;
    logic [31:0] e_od;
    logic       e_ol;
    logic [1:0] e_os;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  function automatic vec_t mkv(input logic r, input logic [3:0] v, input logic [3:0] l,
                               input logic [7:0] d, input logic o, input logic [3:0] er,
                               input logic eb, input logic eov, input logic [31:0] eod,
                               input logic eol, input logic [1:0] eos);
    vec_t t;
    t.rst_n = r;   t.vld = v;      t.lst = l;    t.dat = d;   t.ordy = o;
    t.e_rdy = er;  t.e_busy = eb;  t.e_ov = eov; t.e_od = eod;
    t.e_ol = eol;  t.e_os = eos;
    return t;
  endfunction

  // ---------------- source model for the sequences ----------------
  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
    logic        last;
  } beat_t;

  int    cnt  [N];
  int    lim  [N];
  int    plen [N];
  int    stall_at;
  int    stall_left;
  int    bad_rdy;
  int    bad_busy;
  beat_t obs [$];
  logic  ov_hist [$];

  // Requester i offers beat cnt[i] with payload {i, cnt[i], 16'h0C0D}.
  task automatic drive_lanes();
    for (int i = 0; i < N; i++) begin
      logic v;
      v = (cnt[i] < lim[i]);
      if (i == 0 && stall_left > 0 && cnt[0] == stall_at) begin
        v = 1'b0;
        stall_left--;
      end
      req_valid[i] = v;
      req_last[i]  = ((cnt[i] % plen[i]) == (plen[i] - 1));
      lane_d[i]    = {8'(i), 8'(cnt[i]), 16'h0C0D};
    end
  endtask

  task automatic observe();
    beat_t b;
    ov_hist.push_back(out_valid);
    if (out_valid && out_ready) begin
      b.src  = out_src;
      b.data = out_data;
      b.last = out_last;
      obs.push_back(b);
    end
    if (req_ready[1] && cnt[0] < lim[0]) bad_rdy++;
    if (cnt[0] >= 1 && cnt[0] < lim[0] && !busy) bad_busy++;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) cnt[i]++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive_lanes();
    #1;
    observe();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_lanes();
    #1;
    observe();
  endtask

  task automatic set_model(input int l0, input int l1, input int p0, input int p1, input int p23);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    lim[0] = l0;  lim[1] = l1;  lim[2] = 0;   lim[3] = 0;
    plen[0] = p0; plen[1] = p1; plen[2] = p23; plen[3] = p23;
    stall_at   = 0;
    stall_left = 0;
    bad_rdy    = 0;
    bad_busy   = 0;
    obs.delete();
    ov_hist.delete();
  endtask

  task automatic chk_beat(input string tag, input int k, input int s, input int c, input logic l);
    if (k < obs.size()) begin
      chk($sformatf("%s_beat%0d_src", tag, k),  32'(obs[k].src), 32'(s));
      chk($sformatf("%s_beat%0d_data", tag, k), obs[k].data, {8'(s), 8'(c), 16'h0C0D});
      chk($sformatf("%s_beat%0d_last", tag, k), 32'(obs[k].last), 32'(l));
    end else begin
      chk($sformatf("%s_beat%0d_count", tag, k), 32'(obs.size()), 32'(k + 1));
    end
  endtask

  // Main sequence.
  initial begin
    int f;
    int nbad;
    logic found;

    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) lane_d[i] = '0;
    set_model(0, 0, 1, 1, 1);

    // Reset held 5 cycles with all requesters valid, then requester 0 first.
    for (int k = 0; k < 5; k++)
      tv[k] = mkv(1'b0, 4'b1111, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
    tv[5]  = mkv(1'b1, 4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
    tv[6]  = mkv(1'b1, 4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0001, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
    // Requester 2: three beats A0, A1, A2 (last).
    tv[7]  = mkv(1'b1, 4'b0100, 4'b0000, 8'hA0, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 2'd0);
    tv[8]  = mkv(1'b1, 4'b0100, 4'b0000, 8'hA0, 1'b1, 4'b0100, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
    tv[9]  = mkv(1'b1, 4'b0100, 4'b0000, 8'hA1, 1'b1, 4'b0100, 1'b1, 1'b1, 32'h0200_00A0, 1'b0, 2'd2);
    tv[10] = mkv(1'b1, 4'b0100, 4'b0100, 8'hA2, 1'b1, 4'b0100, 1'b1, 1'b1, 32'h0200_00A1, 1'b0, 2'd2);
    tv[11] = mkv(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0200_00A2, 1'b1, 2'd2);
    tv[12] = mkv(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
    // Requester 0: 0x55 held under 4 cycles of backpressure, then 0x56 (last).
    tv[13] = mkv(1'b1, 4'b0001, 4'b0000, 8'h55, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
    tv[14] = mkv(1'b1, 4'b0001, 4'b0000, 8'h55, 1'b0, 4'b0001, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
    for (int k = 15; k < 19; k++)
      tv[k] = mkv(1'b1, 4'b0001, 4'b0001, 8'h56, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h0000_0055, 1'b0, 2'd0);
    tv[19] = mkv(1'b1, 4'b0001, 4'b0001, 8'h56, 1'b1, 4'b0001, 1'b1, 1'b1, 32'h0000_0055, 1'b0, 2'd0);
    tv[20] = mkv(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b1, 32'h0000_0056, 1'b1, 2'd0);
    tv[21] = mkv(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      rst_n     = tv[k].rst_n;
      req_valid = tv[k].vld;
      req_last  = tv[k].lst;
      out_ready = tv[k].ordy;
      for (int i = 0; i < N; i++) lane_d[i] = {8'(i), 16'h0000, tv[k].dat};
      #1;
      chk($sformatf("v%0d_req_ready", k), 32'(req_ready), 32'(tv[k].e_rdy));
      chk($sformatf("v%0d_busy", k),      32'(busy),      32'(tv[k].e_busy));
      chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(tv[k].e_ov));
      if (tv[k].e_ov || !tv[k].rst_n) begin
        chk($sformatf("v%0d_out_data", k), out_data,        tv[k].e_od);
        chk($sformatf("v%0d_out_last", k), 32'(out_last),   32'(tv[k].e_ol));
        chk($sformatf("v%0d_out_src", k),  32'(out_src),    32'(tv[k].e_os));
      end
    end

    // Fairness: all four send 2-beat packets back to back.
    out_ready = 1'b1;
    set_model(100, 100, 2, 2, 2);
    lim[2] = 100;
    lim[3] = 100;
    apply_reset();
    repeat (31) step();
    for (int n = 0; n < 8; n++) begin
      for (int b = 0; b < 2; b++) chk_beat("fair", 2*n + b, n % 4, 2*(n/4) + b, b[0]);
    end
    f = -1;
    for (int k = 0; k < ov_hist.size(); k++) begin
      if (f < 0 && ov_hist[k]) f = k;
    end
    nbad = 0;
    if (f < 0 || f + 23 > ov_hist.size()) begin
      nbad = 99;
    end else begin
      for (int k = 0; k < 23; k++) begin
        if (ov_hist[f + k] !== ((k % 3) != 2)) nbad++;
      end
    end
    chk("fair_gap_pattern", 32'(nbad), 32'd0);

    // Mid-packet stall: requester 0 (4 beats) pauses 3 cycles, requester 1 waits.
    set_model(4, 1, 4, 1, 1);
    stall_at   = 2;
    stall_left = 3;
    apply_reset();
    repeat (20) step();
    chk("stall_beat_count", 32'(obs.size()), 32'd5);
    chk_beat("stall", 0, 0, 0, 1'b0);
    chk_beat("stall", 1, 0, 1, 1'b0);
    chk_beat("stall", 2, 0, 2, 1'b0);
    chk_beat("stall", 3, 0, 3, 1'b1);
    chk_beat("stall", 4, 1, 0, 1'b1);
    chk("stall_applied", 32'(stall_left), 32'd0);
    chk("stall_early_grant", 32'(bad_rdy), 32'd0);
    chk("stall_busy_drop", 32'(bad_busy), 32'd0);

    // Reset in the middle of a 4-beat packet from requester 1.
    set_model(0, 4, 1, 4, 1);
    apply_reset();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (obs.size() >= 1) found = 1'b1;
    end
    chk("mrst_first_beat_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_req_ready", 32'(req_ready), 32'd0);
    chk("mrst_out_data", out_data, 32'h0000_0000);
    chk("mrst_out_last", 32'(out_last), 32'd0);
    set_model(1, 1, 1, 1, 1);
    apply_reset();
    repeat (12) step();
    chk("mrst_beat_count", 32'(obs.size()), 32'd2);
    chk_beat("mrst", 0, 0, 0, 1'b1);
    chk_beat("mrst", 1, 1, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin packet arbiter that shares one downstream valid/ready stream channel between N_REQ upstream requesters. It grants one requester at a time and holds the grant until that requester's last beat is accepted, so packets never interleave. The output passes through one register stage. It sits between the stimulus-side stream sources and the single-channel DUT datapath that the UVM environment drives and monitors.

## Interface
- N_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 32, payload width in bits.
- SRC_W, $clog2(N_REQ), width of the source index (derived; not overridden).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low (already decided).
- req_valid  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*DATA_W  per-requester payload; requester i uses bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  per-requester end-of-packet flag.
- req_ready  out  N_REQ  per-requester beat accept.
- out_valid  out  1  output beat valid (registered).
- out_data  out  DATA_W  output payload (registered).
- out_last  out  1  output end-of-packet (registered).
- out_src  out  SRC_W  index of the requester that produced the current output beat (registered).
- out_ready  in  1  downstream accept.
- busy  out  1  high while a grant is held (state LOCKED).

## Operation
- State machine states:
  - IDLE: no grant held.
  - LOCKED: grant held by `grant`, an SRC_W-wide register.
- Priority pointer `ptr` holds the last granted index.
  - Search order is ptr+1, ptr+2, ... modulo N_REQ.
  - ptr resets to N_REQ-1, so requester 0 has first priority after reset.
- IDLE → LOCKED: when any req_valid bit is high, the first valid requester in search order is loaded into grant and into ptr. No beat is transferred in this cycle.
- Transfers in LOCKED:
  - req_ready[i] = LOCKED && (i == grant) && (!out_valid || out_ready). All other bits are 0.
  - A beat transfers when req_valid[grant] && req_ready[grant].
  - On a transfer, the output register loads out_data, out_last and out_src = grant, and sets out_valid = 1.
- Output register behaviour:
  - If out_valid && out_ready and no new beat is loaded, out_valid clears.
  - While out_valid && !out_ready, out_data, out_last and out_src are held stable.
- LOCKED → IDLE: on the cycle a beat with req_last = 1 transfers from the granted requester.
- busy = (state == LOCKED).
- No data width conversion. Payload is passed bit-exact.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, out_src 0, req_ready all 0, busy 0, state IDLE, grant 0, ptr N_REQ-1.
- Reset is asynchronous on assertion and releases on the clock edge. Asserting reset mid-packet abandons the packet. Downstream receives no further beats of it, and out_last is not generated.
- Latency, request to first output beat: req_valid rising in cycle T gives grant at edge T+1, transfer in cycle T+1, and out_valid at edge T+2.
- Throughput: 1 beat per cycle while out_ready = 1 and req_valid[grant] = 1.
- Packet gap: one idle arbitration cycle between consecutive packets, which limits packet rate to 1 per (beats+1) cycles.
- Backpressure: out_ready = 0 with out_valid = 1 forces req_ready to 0 in the same cycle. This is a combinational path from out_ready to req_ready.
- Upstream stalls: req_valid[grant] dropping mid-packet stalls the transfer. The grant is kept and other requesters wait.
- Simultaneous requests in IDLE: round-robin from ptr+1. A requester is granted at most once per N_REQ grants while all requesters stay valid.
- Single-beat packet (req_last = 1 on the first beat): LOCKED lasts exactly one transfer cycle.
- Protocol requirement on requesters: req_data and req_last are stable while req_valid && !req_ready. This is checked by bench assertions, not by the block.

## Test plan
- Reset: hold rst_n = 0 for 5 cycles while driving req_valid = 4'b1111 → all outputs at reset values and req_ready = 0. After release, the first grant goes to requester 0.
- Single requester: requester 2 sends a 3-beat packet 0xA0, 0xA1, 0xA2 (last on 0xA2) with out_ready = 1 → out_valid first at edge T+2; beats arrive back-to-back with out_src = 2 and out_last only on 0xA2; busy falls after the third transfer.
- Fairness: all 4 requesters continuously send 2-beat packets → out_src packet order is 0, 1, 2, 3, 0, 1, ...; there is never interleaving within a packet; exactly one idle cycle separates packets.
- Backpressure: out_ready = 0 for 4 cycles while out_valid = 1 with data 0x55 → out_data stays 0x55 and req_ready stays 0. On release, the next beat follows with no loss or duplication.
- Mid-packet stall: the granted requester drops req_valid for 3 cycles mid-packet while requester 1 is valid → no grant change, and requester 1 is served only after the stalled packet's last beat.
- Reset mid-packet: assert rst_n = 0 during beat 2 of a 4-beat packet → out_valid is 0 immediately (asynchronous). After release, arbitration restarts from requester 0 and no stale beats are emitted.
